// File: rtl/mem_port_arbiter_pkg.sv
// Arbiter state, grant encoding and starve-counter sizing for mem_port_arbiter.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_C0 = 2'd1,
      BUSY_C1 = 2'd2
   } arb_state_t;

   typedef logic [1:0] arb_grant_t;

   localparam arb_grant_t arb_grant_none = 2'b00;
   localparam int         STARVE_W       = 8;

   // One-hot owner for a given state; IDLE owns nothing.
   function automatic arb_grant_t arb_grant_of(input arb_state_t s);
      case (s)
         BUSY_C0: return 2'b01;
         BUSY_C1: return 2'b10;
         default: return arb_grant_none;
      endcase
   endfunction

endpackage

// File: rtl/sys.sv
// Shared bus types for the single system memory port (read and write channels).
package sys;

   typedef struct packed {
      logic        en;
      logic [31:0] addr;
   } mem_read_req_t;

   typedef struct packed {
      logic        valid;
      logic        done;
      logic [31:0] data;
   } mem_read_rsp_t;

   typedef struct packed {
      logic        en;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
   } mem_write_req_t;

   typedef struct packed {
      logic done;
   } mem_write_rsp_t;

endpackage

// File: rtl/mem_port_arbiter_perf.sv
// Wrapping event counters for the arbiter: inc[0]=c0 grant, inc[1]=c1 grant, inc[2]=conflict.
module mem_port_arbiter_perf #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       inc,
   output logic [CNT_W-1:0] c0_grants,
   output logic [CNT_W-1:0] c1_grants,
   output logic [CNT_W-1:0] conflicts
);

   for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk) begin
         if (rst) begin
            cnt_reg <= '0;
         end else if (inc[gi]) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end
   end

   assign c0_grants = g_cnt[0].cnt_reg;
   assign c1_grants = g_cnt[1].cnt_reg;
   assign conflicts = g_cnt[2].cnt_reg;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the sys memory port between fetch (c0) and data access (c1) with a starvation guard.
// Define MEM_PORT_ARBITER_PERF_EN to build the grant/conflict performance counters.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int PRIO_CLIENT  = 1,
   parameter int STARVE_LIMIT = 8,
   parameter int CNT_W        = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  sys::mem_read_req_t  c0_read_req,
   output sys::mem_read_rsp_t  c0_read_rsp,
   input  sys::mem_read_req_t  c1_read_req,
   output sys::mem_read_rsp_t  c1_read_rsp,
   input  sys::mem_write_req_t c1_write_req,
   output sys::mem_write_rsp_t c1_write_rsp,
   output sys::mem_read_req_t  mem_read_req,
   input  sys::mem_read_rsp_t  mem_read_rsp,
   output sys::mem_write_req_t mem_write_req,
   input  sys::mem_write_rsp_t mem_write_rsp,
   output arb_grant_t          grant,
   output logic [CNT_W-1:0]    perf_c0_grants,
   output logic [CNT_W-1:0]    perf_c1_grants,
   output logic [CNT_W-1:0]    perf_conflicts
);

   localparam logic                PRIO_IDX   = (PRIO_CLIENT != 0);
   localparam logic                NP_IDX     = ~PRIO_IDX;
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   arb_state_t          state_reg;
   arb_grant_t          grant_reg;
   logic [STARVE_W-1:0] starve_cnt_reg;

   logic [1:0] req;
   logic       both_req;
   logic       starved;
   logic       win_valid;
   logic       win_idx;
   arb_state_t win_state;
   logic       owner_active;
   logic       mem_done;

   // Arbitration decision and exit conditions, all from live client requests.
   always_comb begin
      req       = {c1_read_req.en | c1_write_req.en, c0_read_req.en};
      both_req  = &req;
      starved   = (starve_cnt_reg == STARVE_MAX);
      win_valid = |req;
      if (both_req) begin
         win_idx = starved ? NP_IDX : PRIO_IDX;
      end else begin
         win_idx = req[1];
      end
      win_state = win_idx ? BUSY_C1 : BUSY_C0;
      case (state_reg)
         BUSY_C0: owner_active = req[0];
         BUSY_C1: owner_active = req[1];
         default: owner_active = 1'b0;
      endcase
      mem_done = mem_read_rsp.done | mem_write_rsp.done;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         grant_reg      <= arb_grant_none;
         starve_cnt_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (win_valid) begin
                  state_reg <= win_state;
                  grant_reg <= arb_grant_of(win_state);
                  if (win_idx == NP_IDX) begin
                     starve_cnt_reg <= '0;
                  end else if (both_req && !starved) begin
                     starve_cnt_reg <= starve_cnt_reg + STARVE_W'(1);
                  end
               end
            end
            default: begin
               // Done closes the transaction; dropping every en is an abort.
               if (!owner_active || mem_done) begin
                  state_reg <= IDLE;
                  grant_reg <= arb_grant_none;
               end
            end
         endcase
      end
   end

   assign grant = grant_reg;

   // Owner's request passes straight through; responses only reach an active owner.
   always_comb begin
      mem_read_req  = '0;
      mem_write_req = '0;
      c0_read_rsp   = '0;
      c1_read_rsp   = '0;
      c1_write_rsp  = '0;
      case (state_reg)
         BUSY_C0: begin
            mem_read_req = c0_read_req;
            if (owner_active) begin
               c0_read_rsp = mem_read_rsp;
            end
         end
         BUSY_C1: begin
            mem_read_req    = c1_read_req;
            mem_read_req.en = c1_read_req.en & ~c1_write_req.en;
            mem_write_req   = c1_write_req;
            if (owner_active) begin
               c1_read_rsp  = mem_read_rsp;
               c1_write_rsp = mem_write_rsp;
            end
         end
         default: ;
      endcase
   end

`ifdef MEM_PORT_ARBITER_PERF_EN
   logic [2:0] perf_inc;

   assign perf_inc[0] = (state_reg == IDLE) && win_valid && !win_idx;
   assign perf_inc[1] = (state_reg == IDLE) && win_valid && win_idx;
   assign perf_inc[2] = (state_reg == IDLE) && both_req;

   mem_port_arbiter_perf #(
      .CNT_W (CNT_W)
   ) u_perf (
      .clk       (clk),
      .rst       (rst),
      .inc       (perf_inc),
      .c0_grants (perf_c0_grants),
      .c1_grants (perf_c1_grants),
      .conflicts (perf_conflicts)
   );
`else
   assign perf_c0_grants = '0;
   assign perf_c1_grants = '0;
   assign perf_conflicts = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cycle table, then randomized traffic against a reference model.
module tb_mem_port_arbiter;
   import sys::*;

   localparam int          PRIO     = 1;
   localparam int          LIMIT    = 3;
   localparam int          CW       = 16;
   localparam logic [31:0] C0_ADDR  = 32'h0000_0100;
   localparam logic [31:0] C1_RADDR = 32'h0000_0300;
   localparam logic [31:0] C1_WADDR = 32'h0000_0200;
   localparam logic [31:0] WDATA    = 32'hDEAD_BEEF;
   localparam logic [31:0] MEM_DATA = 32'h1234_5678;

   logic           clk = 1'b0;
   logic           rst;
   mem_read_req_t  c0_read_req, c1_read_req, mem_read_req;
   mem_read_rsp_t  c0_read_rsp, c1_read_rsp, mem_read_rsp;
   mem_write_req_t c1_write_req, mem_write_req;
   mem_write_rsp_t c1_write_rsp, mem_write_rsp;
   logic [1:0]     grant;
   logic [CW-1:0]  perf_c0_grants, perf_c1_grants, perf_conflicts;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .PRIO_CLIENT  (PRIO),
      .STARVE_LIMIT (LIMIT),
      .CNT_W        (CW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .c0_read_req    (c0_read_req),
      .c0_read_rsp    (c0_read_rsp),
      .c1_read_req    (c1_read_req),
      .c1_read_rsp    (c1_read_rsp),
      .c1_write_req   (c1_write_req),
      .c1_write_rsp   (c1_write_rsp),
      .mem_read_req   (mem_read_req),
      .mem_read_rsp   (mem_read_rsp),
      .mem_write_req  (mem_write_req),
      .mem_write_rsp  (mem_write_rsp),
      .grant          (grant),
      .perf_c0_grants (perf_c0_grants),
      .perf_c1_grants (perf_c1_grants),
      .perf_conflicts (perf_conflicts)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [CW-1:0] exp_perf(input int n);
`ifdef MEM_PORT_ARBITER_PERF_EN
      return CW'(n);
`else
      return (n > 0) ? '0 : '0;
`endif
   endfunction

   // One directed cycle: inputs {rst,c0_r,c1_r,c1_w,rdone,wdone}, expected {grant,mr,mw,d0,d1,dw}.
   typedef struct {
      logic       rst, c0_r, c1_r, c1_w, rdone, wdone;
      logic [1:0] g;
      logic       mr, mw, d0, d1, dw;
      int         starve, pc0, pc1, pcf;
   } vec_t;

   function automatic vec_t mk(input logic [5:0] in, input logic [6:0] out,
                               input int st, input int p0, input int p1, input int pf);
      vec_t v;
      {v.rst, v.c0_r, v.c1_r, v.c1_w, v.rdone, v.wdone} = in;
      {v.g, v.mr, v.mw, v.d0, v.d1, v.dw} = out;
      v.starve = st;
      v.pc0    = p0;
      v.pc1    = p1;
      v.pcf    = pf;
      return v;
   endfunction

   task automatic apply_vec(input int idx, input vec_t v);
      @(negedge clk);
      rst                = v.rst;
      c0_read_req.en     = v.c0_r;
      c1_read_req.en     = v.c1_r;
      c1_write_req.en    = v.c1_w;
      mem_read_rsp.valid = v.rdone;
      mem_read_rsp.done  = v.rdone;
      mem_write_rsp.done = v.wdone;
      #1;
      $display("vec %0d grant=%b rd_en=%b wr_en=%b dones=%b%b%b", idx, grant, mem_read_req.en,
               mem_write_req.en, c0_read_rsp.done, c1_read_rsp.done, c1_write_rsp.done);
      check($sformatf("vec%0d.ctl", idx),
            {grant, mem_read_req.en, mem_write_req.en, c0_read_rsp.done, c1_read_rsp.done, c1_write_rsp.done},
            {v.g, v.mr, v.mw, v.d0, v.d1, v.dw});
      if (v.mr) check($sformatf("vec%0d.raddr", idx), mem_read_req.addr, (v.g == 2'b01) ? C0_ADDR : C1_RADDR);
      if (v.mw) check($sformatf("vec%0d.wreq", idx), {mem_write_req.addr, mem_write_req.data, mem_write_req.mask},
                      {C1_WADDR, WDATA, 4'hF});
      if (v.d0) check($sformatf("vec%0d.c0_data", idx), c0_read_rsp.data, MEM_DATA);
      if (v.d1) check($sformatf("vec%0d.c1_data", idx), c1_read_rsp.data, MEM_DATA);
      if (v.starve >= 0) check($sformatf("vec%0d.starve", idx), dut.starve_cnt_reg, v.starve);
      if (v.pc0 >= 0) check($sformatf("vec%0d.perf", idx), {perf_c0_grants, perf_c1_grants, perf_conflicts},
                            {exp_perf(v.pc0), exp_perf(v.pc1), exp_perf(v.pcf)});
   endtask

   // Reference model: owner index (-1 idle), starve count and event totals.
   int m_owner;
   int m_starve;
   int m_cnt[3];

   task automatic run_random(input int n);
      mem_read_req_t  e_rd;
      mem_write_req_t e_wr;
      mem_read_rsp_t  e_c0, e_c1;
      mem_write_rsp_t e_cw;
      logic [1:0]     rq;
      logic           act;
      int             w;
      int             txns;
      txns = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst                 = ($urandom_range(0, 99) == 0);
         c0_read_req.en      = ($urandom_range(0, 3) != 0);
         c0_read_req.addr    = $urandom;
         c1_read_req.en      = ($urandom_range(0, 3) != 0);
         c1_read_req.addr    = $urandom;
         c1_write_req.en     = ($urandom_range(0, 3) == 0);
         c1_write_req.addr   = $urandom;
         c1_write_req.data   = $urandom;
         c1_write_req.mask   = 4'($urandom);
         mem_read_rsp.valid  = ($urandom_range(0, 2) == 0);
         mem_read_rsp.done   = ($urandom_range(0, 2) == 0);
         mem_read_rsp.data   = $urandom;
         mem_write_rsp.done  = ($urandom_range(0, 3) == 0);
         #1;
         rq   = {c1_read_req.en | c1_write_req.en, c0_read_req.en};
         act  = (m_owner >= 0) && rq[m_owner];
         e_rd = '0;
         e_wr = '0;
         e_c0 = '0;
         e_c1 = '0;
         e_cw = '0;
         if (m_owner == 0) begin
            e_rd = c0_read_req;
            if (act) e_c0 = mem_read_rsp;
         end
         if (m_owner == 1) begin
            e_rd    = c1_read_req;
            e_rd.en = c1_read_req.en && !c1_write_req.en;
            e_wr    = c1_write_req;
            if (act) begin
               e_c1 = mem_read_rsp;
               e_cw = mem_write_rsp;
            end
         end
         check("rnd.grant", grant, (m_owner < 0) ? 2'b00 : 2'(1 << m_owner));
         if (m_owner < 0) begin
            check("rnd.idle_en", {mem_read_req.en, mem_write_req.en}, 2'b00);
         end else begin
            check("rnd.mem_read_req", mem_read_req, e_rd);
            check("rnd.mem_write_req", mem_write_req, e_wr);
         end
         check("rnd.rsp", {c0_read_rsp, c1_read_rsp, c1_write_rsp}, {e_c0, e_c1, e_cw});
         check("rnd.perf", {perf_c0_grants, perf_c1_grants, perf_conflicts},
               {exp_perf(m_cnt[0]), exp_perf(m_cnt[1]), exp_perf(m_cnt[2])});
         check("rnd.starve", dut.starve_cnt_reg, m_starve);
         if (act && (mem_read_rsp.done || mem_write_rsp.done)) begin
            txns++;
            $display("rnd txn %0d cycle %0d client %0d", txns, i, m_owner);
         end
         if (rst) begin
            m_owner  = -1;
            m_starve = 0;
            m_cnt    = '{0, 0, 0};
         end else if (m_owner < 0) begin
            if (rq != 2'b00) begin
               if (rq == 2'b11) begin
                  m_cnt[2]++;
                  w = (m_starve == LIMIT) ? 1 - PRIO : PRIO;
                  if (w == PRIO) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
               end else begin
                  w = rq[1] ? 1 : 0;
               end
               if (w != PRIO) m_starve = 0;
               m_cnt[w]++;
               m_owner = w;
            end
         end else if (!act || mem_read_rsp.done || mem_write_rsp.done) begin
            m_owner = -1;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vq[$];
      rst           = 1'b1;
      c0_read_req   = '{en: 1'b0, addr: C0_ADDR};
      c1_read_req   = '{en: 1'b0, addr: C1_RADDR};
      c1_write_req  = '{en: 1'b0, addr: C1_WADDR, data: WDATA, mask: 4'hF};
      mem_read_rsp  = '{valid: 1'b0, done: 1'b0, data: MEM_DATA};
      mem_write_rsp = '{done: 1'b0};

      // reset state
      vq.push_back(mk(6'b000000, 7'b00_00000,  0, 0, 0, 0));
      // lone c0 read, memory done two cycles after en
      vq.push_back(mk(6'b010000, 7'b00_00000, -1, -1, -1, -1));
      vq.push_back(mk(6'b010000, 7'b01_10000, -1, -1, -1, -1));
      vq.push_back(mk(6'b010000, 7'b01_10000, -1, -1, -1, -1));
      vq.push_back(mk(6'b010010, 7'b01_10100, -1, -1, -1, -1));
      vq.push_back(mk(6'b000000, 7'b00_00000, -1, -1, -1, -1));
      // simultaneous requests: c1 first, c0 after the bubble
      vq.push_back(mk(6'b011000, 7'b00_00000,  0, -1, -1, -1));
      vq.push_back(mk(6'b011010, 7'b10_10010,  1, -1, -1, -1));
      vq.push_back(mk(6'b010000, 7'b00_00000, -1, -1, -1, -1));
      vq.push_back(mk(6'b010010, 7'b01_10100,  0, -1, -1, -1));
      vq.push_back(mk(6'b000000, 7'b00_00000, -1, 2, 1, 1));
      // both request continuously: c0 loses three times then wins
      for (int k = 0; k < 3; k++) begin
         vq.push_back(mk(6'b011000, 7'b00_00000, k, -1, -1, -1));
         vq.push_back(mk(6'b011010, 7'b10_10010, k + 1, -1, -1, -1));
      end
      vq.push_back(mk(6'b011000, 7'b00_00000,  3, -1, -1, -1));
      vq.push_back(mk(6'b011010, 7'b01_10100,  0, -1, -1, -1));
      vq.push_back(mk(6'b000000, 7'b00_00000,  0, 3, 4, 5));
      // c1 write
      vq.push_back(mk(6'b000100, 7'b00_00000, -1, -1, -1, -1));
      vq.push_back(mk(6'b000100, 7'b10_01000, -1, -1, -1, -1));
      vq.push_back(mk(6'b000101, 7'b10_01001, -1, -1, -1, -1));
      vq.push_back(mk(6'b000000, 7'b00_00000, -1, -1, -1, -1));
      // c1 aborts in its second busy cycle; late done is dropped
      vq.push_back(mk(6'b001000, 7'b00_00000, -1, -1, -1, -1));
      vq.push_back(mk(6'b001000, 7'b10_10000, -1, -1, -1, -1));
      vq.push_back(mk(6'b000000, 7'b10_00000, -1, -1, -1, -1));
      vq.push_back(mk(6'b000010, 7'b00_00000, -1, -1, -1, -1));
      // reset during BUSY_C0
      vq.push_back(mk(6'b010000, 7'b00_00000, -1, -1, -1, -1));
      vq.push_back(mk(6'b110000, 7'b01_10000, -1, -1, -1, -1));
      vq.push_back(mk(6'b010000, 7'b00_00000,  0, 0, 0, 0));
      vq.push_back(mk(6'b000000, 7'b01_00000, -1, -1, -1, -1));
      vq.push_back(mk(6'b000000, 7'b00_00000, -1, 1, 0, 0));

      repeat (3) @(posedge clk);
      foreach (vq[i]) apply_vec(i, vq[i]);

      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      m_owner  = -1;
      m_starve = 0;
      m_cnt    = '{0, 0, 0};
      run_random(1500);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
